// File: rtl/prom_erase_sequencer_pkg.sv
// Shared definitions for the M25P16 erase/write-status sequencer:
// opcodes, request/error encodings and status register bit positions.
package prom_erase_sequencer_pkg;

    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_RDSR = 8'h05;
    localparam logic [7:0] OPC_SE   = 8'hD8;
    localparam logic [7:0] OPC_BE   = 8'hC7;
    localparam logic [7:0] OPC_WRSR = 8'h01;

    localparam logic [31:0] CMD_WREN = {OPC_WREN, 24'h0};
    localparam logic [31:0] CMD_RDSR = {OPC_RDSR, 24'h0};
    localparam logic [31:0] CMD_BE   = {OPC_BE, 24'h0};

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [1:0] {
        OP_SE      = 2'b00,
        OP_BE      = 2'b01,
        OP_WRSR    = 2'b10,
        OP_ILLEGAL = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_WEL     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ABORT   = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_REL,
        X_ISSUE,
        X_ACK
    } xfer_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_CHK_WEL,
        S_OP,
        S_GAP,
        S_POLL,
        S_FINISH
    } seq_state_e;

    function automatic logic [31:0] op_cmd(input req_op_e op, input logic [23:0] arg);
        case (op)
            OP_SE:   op_cmd = {OPC_SE, arg};
            OP_BE:   op_cmd = CMD_BE;
            OP_WRSR: op_cmd = {OPC_WRSR, arg[7:0], 16'h0};
            default: op_cmd = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/prom_cmd_xfer.sv
// One engine transaction: wait for a stale clear to drop, present the command
// until the engine acknowledges, then withdraw it and wait for clear to fall.
module prom_cmd_xfer
    import prom_erase_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cmd,
    output logic [31:0] prom_cmd,
    input  logic        prom_cmd_clear,
    input  logic [31:0] prom_result,
    output logic        xfer_done,
    output logic [31:0] result
);

    xfer_state_e state;
    logic [31:0] cmd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= X_IDLE;
            cmd_q     <= 32'h0;
            prom_cmd  <= 32'h0;
            xfer_done <= 1'b0;
            result    <= 32'h0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                X_IDLE: begin
                    if (start) begin
                        cmd_q <= cmd;
                        // Skip REL when the engine is already quiet so the
                        // command appears on the cycle after start.
                        if (!prom_cmd_clear) begin
                            prom_cmd <= cmd;
                            state    <= X_ISSUE;
                        end else begin
                            state <= X_REL;
                        end
                    end
                end
                X_REL: begin
                    if (!prom_cmd_clear) begin
                        prom_cmd <= cmd_q;
                        state    <= X_ISSUE;
                    end
                end
                X_ISSUE: begin
                    if (prom_cmd_clear) begin
                        result   <= prom_result;
                        prom_cmd <= 32'h0;
                        state    <= X_ACK;
                    end
                end
                X_ACK: begin
                    if (!prom_cmd_clear) begin
                        xfer_done <= 1'b1;
                        state     <= X_IDLE;
                    end
                end
                default: state <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prom_erase_sequencer.sv
// Sequences WREN, WEL check, the erase/write-status command and WIP polling
// on top of the single-command PROM SPI engine.
//
// state     | meaning
// S_IDLE    | ready for a request
// S_WREN    | write-enable xfer in flight
// S_CHK_WEL | RDSR xfer to confirm WEL
// S_OP      | SE/BE/WRSR xfer in flight
// S_GAP     | idle spacing before the next RDSR poll
// S_POLL    | RDSR poll xfer in flight
// S_FINISH  | report done/error, then back to idle
module prom_erase_sequencer
    import prom_erase_sequencer_pkg::*;
#(
    parameter int POLL_GAP   = 4096,
    parameter int POLL_CNT_W = 20,
    parameter int MAX_POLLS  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_arg,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  last_status,
    output logic [31:0] prom_cmd,
    input  logic        prom_cmd_clear,
    input  logic [31:0] prom_result
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    seq_state_e            state;
    req_op_e               op_q;
    logic [23:0]           arg_q;
    logic                  abort_q;
    logic                  abort_eff;
    logic [GAP_W-1:0]      gap_cnt;
    logic [POLL_CNT_W-1:0] poll_cnt;
    logic [POLL_CNT_W-1:0] poll_next;
    logic                  timeout;
    logic                  xfer_start;
    logic [31:0]           xfer_cmd;
    logic                  xfer_done;
    logic [31:0]           xfer_result;
    logic                  unused_result;

    assign abort_eff     = abort | abort_q;
    assign poll_next     = poll_cnt + POLL_CNT_W'(1);
    assign timeout       = (poll_next == POLL_CNT_W'(MAX_POLLS));
    assign unused_result = ^xfer_result[31:8];

    // Next xfer is launched on the same edge the FSM leaves the previous one.
    always_comb begin
        xfer_start = 1'b0;
        xfer_cmd   = 32'h0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_op != OP_ILLEGAL) begin
                    xfer_start = 1'b1;
                    xfer_cmd   = CMD_WREN;
                end
            end
            S_WREN: begin
                if (xfer_done && !abort_eff) begin
                    xfer_start = 1'b1;
                    xfer_cmd   = CMD_RDSR;
                end
            end
            S_CHK_WEL: begin
                if (xfer_done && xfer_result[SR_WEL] && !abort_eff) begin
                    xfer_start = 1'b1;
                    xfer_cmd   = op_cmd(op_q, arg_q);
                end
            end
            S_GAP: begin
                if (!abort_eff && gap_cnt == '0) begin
                    xfer_start = 1'b1;
                    xfer_cmd   = CMD_RDSR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_SE;
            arg_q       <= 24'h0;
            abort_q     <= 1'b0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_OK;
            last_status <= 8'h0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE)
                abort_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op_e'(req_op);
                        arg_q     <= req_arg;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        error     <= 1'b0;
                        abort_q   <= 1'b0;
                        poll_cnt  <= '0;
                        if (req_op == OP_ILLEGAL) begin
                            err_code <= ERR_ABORT;
                            state    <= S_FINISH;
                        end else begin
                            err_code <= ERR_OK;
                            state    <= S_WREN;
                        end
                    end
                end
                S_WREN: begin
                    if (xfer_done) begin
                        if (abort_eff) begin
                            err_code <= ERR_ABORT;
                            state    <= S_FINISH;
                        end else begin
                            state <= S_CHK_WEL;
                        end
                    end
                end
                S_CHK_WEL: begin
                    if (xfer_done) begin
                        last_status <= xfer_result[7:0];
                        if (!xfer_result[SR_WEL]) begin
                            err_code <= ERR_WEL;
                            state    <= S_FINISH;
                        end else if (abort_eff) begin
                            err_code <= ERR_ABORT;
                            state    <= S_FINISH;
                        end else begin
                            state <= S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (xfer_done) begin
                        poll_cnt <= '0;
                        gap_cnt  <= GAP_W'(POLL_GAP - 1);
                        if (abort_eff) begin
                            err_code <= ERR_ABORT;
                            state    <= S_FINISH;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (abort_eff) begin
                        err_code <= ERR_ABORT;
                        state    <= S_FINISH;
                    end else if (gap_cnt == '0) begin
                        state <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_POLL: begin
                    if (xfer_done) begin
                        last_status <= xfer_result[7:0];
                        poll_cnt    <= poll_next;
                        gap_cnt     <= GAP_W'(POLL_GAP - 1);
                        // Completion outranks timeout, which outranks abort.
                        if (!xfer_result[SR_WIP]) begin
                            state <= S_FINISH;
                        end else if (timeout) begin
                            err_code <= ERR_TIMEOUT;
                            state    <= S_FINISH;
                        end else if (abort_eff) begin
                            err_code <= ERR_ABORT;
                            state    <= S_FINISH;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_FINISH: begin
                    done      <= 1'b1;
                    error     <= (err_code != ERR_OK);
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    prom_cmd_xfer u_xfer (
        .clk            (clk),
        .reset          (reset),
        .start          (xfer_start),
        .cmd            (xfer_cmd),
        .prom_cmd       (prom_cmd),
        .prom_cmd_clear (prom_cmd_clear),
        .prom_result    (prom_result),
        .xfer_done      (xfer_done),
        .result         (xfer_result)
    );

endmodule

// File: tb/tb_prom_erase_sequencer.sv
// Scoreboard bench for prom_erase_sequencer against a behavioural SPI engine model.
module tb_prom_erase_sequencer;
    import prom_erase_sequencer_pkg::*;

    localparam int POLL_GAP  = 4;
    localparam int MAX_POLLS = 5;
    localparam int CNT_W     = 8;
    localparam int ENG_LAT   = 3;

    typedef struct packed {
        logic [1:0] err;
        logic       error;
        logic [7:0] ls;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [23:0] req_arg = 24'h0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  last_status;
    logic [31:0] prom_cmd;
    logic        prom_cmd_clear = 1'b0;
    logic [31:0] prom_result = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [31:0] cmd_q[$];
    res_t        res_q[$];

    // engine model state
    logic        wel = 1'b1;
    int          wip_polls = 0;
    int          rdsr_idx = 0;
    int          lat = 0;
    logic        hold_clear = 1'b0;

    // monitor state
    logic [31:0] prev_cmd = 32'h0;
    logic [31:0] last_cmd = 32'h0;
    int          zero_run = 0;

    prom_erase_sequencer #(
        .POLL_GAP   (POLL_GAP),
        .POLL_CNT_W (CNT_W),
        .MAX_POLLS  (MAX_POLLS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_arg        (req_arg),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .last_status    (last_status),
        .prom_cmd       (prom_cmd),
        .prom_cmd_clear (prom_cmd_clear),
        .prom_result    (prom_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eng_resp(input logic [31:0] c, input int idx);
        if (c != CMD_RDSR) return 32'h0;
        if (idx == 0) return {30'h0, wel, 1'b0};
        return (idx <= wip_polls) ? 32'h03 : 32'h00;
    endfunction

    // clear rises ENG_LAT edges after a nonzero command, falls one edge after it is withdrawn
    always @(posedge clk) begin
        if (prom_cmd == 32'h0) begin
            lat <= 0;
            if (!hold_clear) prom_cmd_clear <= 1'b0;
        end else if (!prom_cmd_clear) begin
            if (lat == ENG_LAT - 1) begin
                prom_cmd_clear <= 1'b1;
                prom_result    <= eng_resp(prom_cmd, rdsr_idx);
                if (prom_cmd == CMD_WREN) rdsr_idx <= 0;
                else if (prom_cmd == CMD_RDSR) rdsr_idx <= rdsr_idx + 1;
            end else begin
                lat <= lat + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prom_cmd != prev_cmd && prom_cmd != 32'h0) begin
                if (prev_cmd != 32'h0) chk("cmd_zero_between", prev_cmd, 32'h0);
                if (cmd_q.size() == 0) chk("cmd_unexpected", prom_cmd, 32'h0);
                else chk("cmd_seq", prom_cmd, cmd_q.pop_front());
                if (prom_cmd == CMD_RDSR && last_cmd != CMD_WREN)
                    chk("poll_gap", 32'(zero_run >= POLL_GAP), 32'h1);
                last_cmd = prom_cmd;
                zero_run = 0;
            end else if (prom_cmd == 32'h0) begin
                zero_run++;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", {31'h0, done}, 32'h0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("err_code", {30'h0, err_code}, {30'h0, r.err});
                    chk("error", {31'h0, error}, {31'h0, r.error});
                    chk("last_status", {24'h0, last_status}, {24'h0, r.ls});
                    chk("ready_at_done", {31'h0, req_ready}, 32'h1);
                end
            end
        end
        prev_cmd = prom_cmd;
    end

    task automatic send_req(input logic [1:0] op, input logic [23:0] arg);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk(tag, 32'h0, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nz;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        chk("rst_err_code", {30'h0, err_code}, 32'h0);
        chk("rst_status", {24'h0, last_status}, 32'h0);
        chk("rst_cmd", prom_cmd, 32'h0);

        // 1: sector erase, WIP for 3 polls
        wel = 1'b1; wip_polls = 3;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(32'hD81F0000);
        repeat (4) cmd_q.push_back(CMD_RDSR);
        res_q.push_back('{err: 2'b00, error: 1'b0, ls: 8'h00});
        send_req(2'b00, 24'h1F0000);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        chk("t1_ready", {31'h0, req_ready}, 32'h0);
        wait_done("t1_done_timeout");

        // 2: write status with WEL never set
        wel = 1'b0; wip_polls = 0;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        res_q.push_back('{err: 2'b01, error: 1'b1, ls: 8'h00});
        send_req(2'b10, 24'h00001C);
        wait_done("t2_done_timeout");

        // 3: bulk erase, WIP stuck -> poll timeout
        wel = 1'b1; wip_polls = 1000;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(CMD_BE);
        repeat (MAX_POLLS) cmd_q.push_back(CMD_RDSR);
        res_q.push_back('{err: 2'b10, error: 1'b1, ls: 8'h03});
        send_req(2'b01, 24'hABCDEF);
        wait_done("t3_done_timeout");
        repeat (20) @(negedge clk);

        // 4: abort during the SE transaction
        wel = 1'b1; wip_polls = 2;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(32'hD8012345);
        res_q.push_back('{err: 2'b11, error: 1'b1, ls: 8'h02});
        send_req(2'b00, 24'h012345);
        for (int i = 0; i < 200; i++) begin
            if (prom_cmd == 32'hD8012345) break;
            @(negedge clk);
        end
        chk("t4_op_seen", prom_cmd, 32'hD8012345);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_op_held", prom_cmd, 32'hD8012345);
        wait_done("t4_done_timeout");
        repeat (20) @(negedge clk);

        // 5: illegal op, plus a request while busy
        res_q.push_back('{err: 2'b11, error: 1'b1, ls: 8'h02});
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_arg = 24'h0;
        @(negedge clk);
        chk("t5_done_early", {31'h0, done}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h1);
        chk("t5_ready", {31'h0, req_ready}, 32'h0);
        req_op = 2'b01;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_done_2cyc", {31'h0, done}, 32'h1);
        repeat (10) @(negedge clk);
        chk("t5_busy_ignored", {31'h0, busy}, 32'h0);

        // 6: reset during POLL with clear held, then a stalled new request
        wel = 1'b1; wip_polls = 1000;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(32'hD8200000);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(CMD_RDSR);
        send_req(2'b00, 24'h200000);
        for (int i = 0; i < 500; i++) begin
            if (cmd_q.size() == 0 && prom_cmd_clear) break;
            @(negedge clk);
        end
        chk("t6_in_poll", {31'h0, prom_cmd_clear}, 32'h1);
        hold_clear = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_cmd", prom_cmd, 32'h0);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_ready", {31'h0, req_ready}, 32'h1);
        chk("t6_err_code", {30'h0, err_code}, 32'h0);
        chk("t6_status", {24'h0, last_status}, 32'h0);
        wip_polls = 0;
        cmd_q.push_back(CMD_WREN);
        cmd_q.push_back(CMD_RDSR);
        cmd_q.push_back(32'h011C0000);
        cmd_q.push_back(CMD_RDSR);
        res_q.push_back('{err: 2'b00, error: 1'b0, ls: 8'h00});
        send_req(2'b10, 24'h00001C);
        nz = 0;
        repeat (6) begin
            @(negedge clk);
            if (prom_cmd != 32'h0) nz++;
        end
        chk("t6_rel_stall", nz, 0);
        hold_clear = 1'b0;
        wait_done("t6_done_timeout");

        chk("cmd_q_left", cmd_q.size(), 0);
        chk("res_q_left", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
